xor_share_arb: RTL and testbench
================================

XOR_SHARE_ARB -- requirements
Module: xor_share_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents an operation.
REQ-005 The block SHALL have port req0_a, input, WIDTH bits: requester 0 operand a.
REQ-006 The block SHALL have port req0_b, input, WIDTH bits: requester 0 operand b.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_a, req1_b and req1_ready, with the same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: result held and valid.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: the requester that owns the result.
REQ-011 The block SHALL have port rsp_y, output, WIDTH bits: the result a ^ b.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-013 The block SHALL share one bitwise XOR unit between both requesters; the result SHALL be rsp_y = a ^ b of the granted requester, bit-for-bit, with no width extension.
REQ-014 An FSM SHALL have two states: EMPTY (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-015 accept_en SHALL equal (state==EMPTY) || rsp_ready.
REQ-016 A transfer SHALL occur when accept_en is high and at least one reqN_valid is high.
REQ-017 Grant, one requester only: that requester SHALL be granted.
REQ-018 Grant, both requesters valid: the requester that is not last_grant SHALL be granted (round-robin).
REQ-019 reqN_ready SHALL be high only in a cycle where requester N is granted and a transfer occurs.
REQ-020 At most one of req0_ready and req1_ready SHALL be high in any cycle.
REQ-021 reqN_ready MAY depend combinationally on reqN_valid and rsp_ready.
REQ-022 rsp_y, rsp_id, rsp_valid and last_grant SHALL be registered.
REQ-023 Latency: a transfer in cycle T SHALL give rsp_valid=1 with the new rsp_y and rsp_id in cycle T+1.
REQ-024 On a transfer, last_grant SHALL be set to the granted id.
REQ-025 EMPTY -> HOLD on a transfer.
REQ-026 HOLD + rsp_ready + transfer: HOLD SHALL be kept and the new result loaded, giving back-to-back throughput of one result per cycle.
REQ-027 HOLD + rsp_ready + no request: the FSM SHALL go to EMPTY.
REQ-028 HOLD + !rsp_ready: rsp_y and rsp_id SHALL be held stable, both reqN_ready SHALL be 0, and last_grant SHALL be unchanged.
REQ-029 While unaccepted, requester inputs are permitted to change; the block SHALL sample them only in the cycle of the transfer.
REQ-030 A requester holding valid SHALL be granted within 2 transfers (no starvation).

Reset
REQ-031 While rst_n=0, regardless of clk, state SHALL be EMPTY, with rsp_valid=0, rsp_id=0, rsp_y=0 and last_grant=1, so that requester 0 wins the first contention.
REQ-032 Reset asserted mid-operation SHALL discard any held result immediately, with no response emitted.
REQ-033 The first transfer SHALL be possible in the first rising edge after rst_n deasserts.

Verification
REQ-034 Reset, then req0 only, a=8'h0F, b=8'hFF, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_y=8'hF0.
REQ-035 Both valid for 4 cycles, req0 a^b=8'hAA, req1 a^b=8'h55, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 with matching rsp_y on consecutive cycles.
REQ-036 Result held (rsp_id=0, rsp_y=8'h3C), rsp_ready=0 for 5 cycles, both requesters valid -> no readys, rsp_y stable at 8'h3C; when rsp_ready=1, requester 1 is granted.
REQ-037 Truth table per bit, requester 1: a=8'h00/b=8'h00 -> 8'h00; 8'h00/8'hFF -> 8'hFF; 8'hFF/8'h00 -> 8'hFF; 8'hFF/8'hFF -> 8'h00.
REQ-038 rst_n pulsed low asynchronously (between clk edges) while in HOLD -> rsp_valid=0 and rsp_y=0 immediately; after release, a contended request grants requester 0.
REQ-039 Random valid/rsp_ready traffic for 1000 cycles -> a scoreboard finds every accepted operation returned once, in order, with correct id and a^b, and never both readys high.

Source files
------------

// File: rtl/xor_share_arb.sv
// xor_share_arb: two requesters share one bitwise XOR unit through a
// round-robin arbiter; the result sits in a single-entry output register.
module xor_share_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   input  logic             rsp_ready
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_grant;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_y;

   logic             w_accept_en;
   logic             w_xfer;
   logic             w_grant;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_xor;

   // State register; reset leaves the output register empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Arbitration, handshake and next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept_en = (r_state == ST_EMPTY) || rsp_ready;
      w_grant     = 1'b0;
      w_xfer      = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;

      // Contention goes to whoever did not win last; otherwise the lone requester.
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end

      w_xfer     = w_accept_en && (req0_valid || req1_valid);
      req0_ready = w_xfer && !w_grant;
      req1_ready = w_xfer &&  w_grant;

      case (r_state)
         ST_EMPTY: begin
            if (w_xfer) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A taken result is replaced in the same cycle when a new one arrives.
            if (rsp_ready && !w_xfer) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Operand select feeding the single shared XOR unit.
   always_comb begin
      w_op_a = w_grant ? req1_a : req0_a;
      w_op_b = w_grant ? req1_b : req0_b;
      w_xor  = w_op_a ^ w_op_b;
   end

   // Result and arbitration history, loaded only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_y      <= '0;
         r_rsp_id     <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_xfer) begin
         r_rsp_y      <= w_xor;
         r_rsp_id     <= w_grant;
         r_last_grant <= w_grant;
      end
   end

   assign rsp_valid = (r_state == ST_HOLD);
   assign rsp_id    = r_rsp_id;
   assign rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed and randomized checks for xor_share_arb.
module tb_xor_share_arb;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_a = '0;
   logic [W-1:0] req0_b = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_a = '0;
   logic [W-1:0] req1_b = '0;
   logic         req1_ready;
   logic         rsp_valid;
   logic         rsp_id;
   logic [W-1:0] rsp_y;
   logic         rsp_ready = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   logic [W:0] sbq[$];
   logic       m_last;
   logic       m_valid;

   xor_share_arb #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp_ready  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // One cycle of traffic checked against a reference arbiter and FIFO scoreboard.
   task automatic rand_cycle(input bit drain);
      logic g;
      logic xfer;
      if (drain) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         rsp_ready  = 1'b1;
      end else begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_a     = W'($urandom);
         req0_b     = W'($urandom);
         req1_a     = W'($urandom);
         req1_b     = W'($urandom);
         rsp_ready  = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      chk("rnd_excl", 32'(req0_ready & req1_ready), 32'd0);
      chk("rnd_valid", 32'(rsp_valid), 32'(m_valid));
      if (rsp_valid) begin
         if (sbq.size() == 0) begin
            chk("rnd_sb_empty", 32'd1, 32'd0);
         end else begin
            chk("rnd_id", 32'(rsp_id), 32'(sbq[0][W]));
            chk("rnd_y", 32'(rsp_y), 32'(sbq[0][W-1:0]));
            if (rsp_ready) void'(sbq.pop_front());
         end
      end
      g    = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      xfer = (!m_valid || rsp_ready) && (req0_valid || req1_valid);
      chk("rnd_r0", 32'(req0_ready), 32'(xfer && !g));
      chk("rnd_r1", 32'(req1_ready), 32'(xfer && g));
      if (xfer) begin
         sbq.push_back(g ? {1'b1, req1_a ^ req1_b} : {1'b0, req0_a ^ req0_b});
         m_valid = 1'b1;
         m_last  = g;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      cyc();
   endtask

   initial begin : main
      logic [W-1:0] ta [4];
      logic [W-1:0] tb [4];
      logic [W-1:0] ty [4];

      // Reset values while rst_n is held low.
      #2;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_y", 32'(rsp_y), 32'd0);

      // Single requester 0, transfer on first edge after reset release.
      do_reset();
      req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hFF; rsp_ready = 1'b1;
      @(negedge clk);
      chk("s0_r0", 32'(req0_ready), 32'd1);
      chk("s0_r1", 32'(req1_ready), 32'd0);
      chk("s0_pre_valid", 32'(rsp_valid), 32'd0);
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("s0_valid", 32'(rsp_valid), 32'd1);
      chk("s0_id", 32'(rsp_id), 32'd0);
      chk("s0_y", 32'(rsp_y), 32'hF0);
      cyc();
      @(negedge clk);
      chk("s0_empty", 32'(rsp_valid), 32'd0);

      // Contention after reset: round-robin 0,1,0,1 back to back.
      do_reset();
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h5A;
      req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h5A;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 4) begin
            chk("rr_r0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("rr_r1", 32'(req1_ready), 32'((i % 2) == 1));
         end
         if (i > 0) begin
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(((i - 1) % 2) == 1));
            chk("rr_y", 32'(rsp_y), ((i - 1) % 2 == 1) ? 32'h55 : 32'hAA);
         end
         cyc();
      end

      // Hold under backpressure while requesters wiggle their operands.
      req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h00; rsp_ready = 1'b1;
      cyc();
      rsp_ready  = 1'b0;
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req0_a = W'(8'h11 + i); req0_b = 8'h22;
         req1_a = W'(8'h12 + i); req1_b = 8'h34;
         @(negedge clk);
         chk("hold_r0", 32'(req0_ready), 32'd0);
         chk("hold_r1", 32'(req1_ready), 32'd0);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_id", 32'(rsp_id), 32'd0);
         chk("hold_y", 32'(rsp_y), 32'h3C);
         cyc();
      end
      req1_a = 8'h12; req1_b = 8'h34;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_rel_r1", 32'(req1_ready), 32'd1);
      chk("hold_rel_r0", 32'(req0_ready), 32'd0);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("hold_rel_id", 32'(rsp_id), 32'd1);
      chk("hold_rel_y", 32'(rsp_y), 32'h26);
      cyc();

      // Per-bit truth table through requester 1.
      ta[0] = 8'h00; tb[0] = 8'h00; ty[0] = 8'h00;
      ta[1] = 8'h00; tb[1] = 8'hFF; ty[1] = 8'hFF;
      ta[2] = 8'hFF; tb[2] = 8'h00; ty[2] = 8'hFF;
      ta[3] = 8'hFF; tb[3] = 8'hFF; ty[3] = 8'h00;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            req1_valid = 1'b1; req1_a = ta[i]; req1_b = tb[i];
         end else begin
            req1_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 4) chk("tt_r1", 32'(req1_ready), 32'd1);
         if (i > 0) begin
            chk("tt_id", 32'(rsp_id), 32'd1);
            chk("tt_y", 32'(rsp_y), 32'(ty[i-1]));
         end
         cyc();
      end

      // Asynchronous reset between edges while holding a result.
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F; rsp_ready = 1'b0;
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("ar_pre_valid", 32'(rsp_valid), 32'd1);
      chk("ar_pre_y", 32'(rsp_y), 32'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(rsp_valid), 32'd0);
      chk("ar_y", 32'(rsp_y), 32'd0);
      chk("ar_id", 32'(rsp_id), 32'd0);
      #1;
      rst_n = 1'b1;
      cyc();
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h08;
      rsp_ready  = 1'b1;
      @(negedge clk);
      chk("ar_grant_r0", 32'(req0_ready), 32'd1);
      chk("ar_grant_r1", 32'(req1_ready), 32'd0);
      cyc();

      // Random traffic with a reference arbiter and in-order scoreboard.
      do_reset();
      m_last  = 1'b1;
      m_valid = 1'b0;
      sbq.delete();
      for (int i = 0; i < 1000; i++) rand_cycle(1'b0);
      for (int i = 0; i < 3; i++) rand_cycle(1'b1);
      chk("rnd_drain", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
